// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and the reference round-robin pick used by the arbiter.
package shared_reg_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int WR_CNT_W = 16;
    localparam int MAXREQ   = 8;

    // First set bit of req searching upward from ptr, modulo n; returns one-hot.
    function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] req,
                                                   input logic [2:0]        ptr,
                                                   input int                n);
        logic [MAXREQ-1:0] g;
        int                idx;
        g = '0;
        for (int k = MAXREQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx[2:0]]) begin
                    g = '0;
                    g[idx[2:0]] = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick_comb.sv
// Combinational round-robin encoder: rotate by ptr, take lowest set bit, rotate back.
// Zero latency; no flow control.
module rr_pick_comb #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic [2*NREQ-1:0] req2;
    logic [2*NREQ-1:0] gnt2;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   rot_gnt;

    assign req2    = {req, req};
    assign rot     = req2[ptr +: NREQ];
    assign rot_gnt = rot & (~rot + NREQ'(1));
    assign gnt2    = {rot_gnt, rot_gnt};
    // rot_gnt bit j stands for requester (j+ptr) mod NREQ; shift back by ptr
    assign gnt     = gnt2[NREQ - int'(ptr) +: NREQ];

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner of one shared DW-bit register; grant one cycle after request,
// write commits while granted and requesting, lock holds ownership up to MAXHOLD cycles.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int MAXHOLD = 4
) (
    input  logic                clk,
    input  logic                reset_l,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     lock,
    input  logic [NREQ*DW-1:0]  wdata,
    output logic [NREQ-1:0]     gnt,
    output logic                gnt_vld,
    output logic [DW-1:0]       shared_q,
    output logic [WR_CNT_W-1:0] wr_cnt
);

    localparam int PW = $clog2(NREQ);
    localparam int HW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     next_ptr, arb_ptr, pick_idx;
    logic [HW-1:0]     hold_q, hold_d;
    logic [NREQ-1:0]   pick;
    logic              owner_req, owner_lock, release_now, commit;

    assign owner_req  = req[owner_q];
    assign owner_lock = lock[owner_q];
    assign commit     = (state_q == OWN) && owner_req;
    assign next_ptr   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
    // On a release edge the search already starts past the departing owner
    assign arb_ptr    = (state_q == OWN) ? next_ptr : rr_ptr_q;

    rr_pick_comb #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (arb_ptr),
        .gnt (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        hold_d      = hold_q;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pick) begin
                    state_d = OWN;
                    gnt_d   = pick;
                    owner_d = pick_idx;
                    hold_d  = '0;
                end
            end
            OWN: begin
                release_now = !owner_req || !owner_lock || (hold_q == HW'(MAXHOLD - 1));
                if (release_now) begin
                    rr_ptr_d = next_ptr;
                    hold_d   = '0;
                    if (|pick) begin
                        gnt_d   = pick;
                        owner_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q  <= IDLE;
            gnt      <= '0;
            gnt_vld  <= 1'b0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt      <= gnt_d;
            gnt_vld  <= |gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            shared_q <= '0;
            wr_cnt   <= '0;
        end else if (commit) begin
            shared_q <= wdata[owner_q*DW +: DW];
            wr_cnt   <= wr_cnt + WR_CNT_W'(1);
        end
    end

    logic [MAXREQ-1:0] pick_ref;
    always_comb pick_ref = rr_pick(MAXREQ'(req), 3'(arb_ptr), NREQ);

    always @(posedge clk) begin
        if (reset_l) begin
            assert ($onehot0(gnt));
            assert (gnt_vld == |gnt);
            assert (pick_ref == MAXREQ'(pick));
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: round-robin, bursts, withdraw, regrant, reset, wrap.
module tb_shared_reg_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int MAXHOLD = 4;

    logic              clk = 1'b0;
    logic              reset_l;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic              gnt_vld;
    logic [DW-1:0]     shared_q;
    logic [15:0]       wr_cnt;

    int checks = 0;
    int errors = 0;

    shared_reg_arbiter #(.NREQ(NREQ), .DW(DW), .MAXHOLD(MAXHOLD)) dut (
        .clk      (clk),
        .reset_l  (reset_l),
        .req      (req),
        .lock     (lock),
        .wdata    (wdata),
        .gnt      (gnt),
        .gnt_vld  (gnt_vld),
        .shared_q (shared_q),
        .wr_cnt   (wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] g, input logic [7:0] q,
                               input logic [15:0] c);
        check({tag, ".gnt"}, 32'(gnt), 32'(g));
        check({tag, ".vld"}, 32'(gnt_vld), 32'(|g));
        check({tag, ".q"}, 32'(shared_q), 32'(q));
        check({tag, ".cnt"}, 32'(wr_cnt), 32'(c));
    endtask

    initial begin
        reset_l = 1'b0;
        req     = '0;
        lock    = '0;
        wdata   = '0;
        #12;
        check_state("reset", 4'b0000, 8'h00, 16'd0);
        reset_l = 1'b1;

        // Single writes around the ring, no bubbles
        req   = 4'b1111;
        lock  = 4'b0000;
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        tick; check_state("rr0", 4'b0001, 8'h00, 16'd0);
        tick; check_state("rr1", 4'b0010, 8'h10, 16'd1);
        tick; check_state("rr2", 4'b0100, 8'h11, 16'd2);
        tick; check_state("rr3", 4'b1000, 8'h12, 16'd3);
        tick; check_state("rr4", 4'b0001, 8'h13, 16'd4);
        req = 4'b0000;
        tick; check_state("rr_idle", 4'b0000, 8'h13, 16'd4);

        // Withdraw while granted: no write, back to idle
        req = 4'b0010;
        tick; check_state("wd_gnt", 4'b0010, 8'h13, 16'd4);
        req = 4'b0000;
        tick; check_state("wd_rel", 4'b0000, 8'h13, 16'd4);

        // Burst limit: pointer now at 2, so requester 0 wins first
        req   = 4'b0011;
        lock  = 4'b0011;
        wdata = {8'h00, 8'h00, 8'h21, 8'h20};
        for (int k = 0; k < 4; k++) begin
            tick; check_state("burst0", 4'b0001, (k == 0) ? 8'h13 : 8'h20, 16'(4 + k));
        end
        for (int k = 0; k < 4; k++) begin
            tick; check_state("burst1", 4'b0010, (k == 0) ? 8'h20 : 8'h21, 16'(8 + k));
        end
        tick; check_state("burst_back", 4'b0001, 8'h21, 16'd12);

        // Lone locked requester: forced release regrants with no idle cycle
        req   = 4'b0100;
        lock  = 4'b0100;
        wdata = {8'h00, 8'h30, 8'h00, 8'h00};
        tick; check_state("lone0", 4'b0100, 8'h21, 16'd12);
        for (int k = 1; k < 6; k++) begin
            tick; check_state("lone", 4'b0100, 8'h30, 16'(12 + k));
        end
        req  = 4'b0000;
        lock = 4'b0000;
        tick; check_state("lone_idle", 4'b0000, 8'h30, 16'd17);

        // Reset mid-burst; pointer is at 3 here so a post-reset 0001 grant proves it cleared
        req   = 4'b0001;
        lock  = 4'b0001;
        wdata = {8'h00, 8'h00, 8'h00, 8'h5A};
        tick; check_state("mid0", 4'b0001, 8'h30, 16'd17);
        tick; check_state("mid1", 4'b0001, 8'h5A, 16'd18);
        #2 reset_l = 1'b0;
        #1 check_state("mid_rst", 4'b0000, 8'h00, 16'd0);
        #2 reset_l = 1'b1;
        req   = 4'b1111;
        lock  = 4'b0000;
        wdata = {8'h43, 8'h42, 8'h41, 8'h40};
        tick; check_state("post_rst", 4'b0001, 8'h00, 16'd0);

        // Counter wrap via continuous single-write regrants of requester 0
        req   = 4'b0001;
        wdata = {8'h00, 8'h00, 8'h00, 8'h77};
        repeat (65534) tick;
        check_state("wrap_fffe", 4'b0001, 8'h77, 16'hFFFE);
        tick; check("wrap_ffff", 32'(wr_cnt), 32'h0000_FFFF);
        tick; check("wrap_0000", 32'(wr_cnt), 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
